// File: rtl/param_sync_fifo.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty flags and ovf/udf pulses.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is a 1-cycle registered read.
module param_sync_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rinc,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  output logic              udf
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr_reg, rptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              full_reg, empty_reg, almost_full_reg, almost_empty_reg;
  logic              ovf_reg, udf_reg;
  logic              we, re;

  assign we = winc & ~full_reg;
  assign re = rinc & ~empty_reg;

  always_comb begin
    count_next = count_reg;
    if (we && !re)
      count_next = count_reg + CNT_W'(1);
    else if (re && !we)
      count_next = count_reg - CNT_W'(1);
  end

  // Flags are computed from count_next so they track count exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg         <= '0;
      rptr_reg         <= '0;
      count_reg        <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
      ovf_reg          <= 1'b0;
      udf_reg          <= 1'b0;
    end else begin
      if (we)
        wptr_reg <= wptr_reg + AW'(1);
      if (re)
        rptr_reg <= rptr_reg + AW'(1);
      count_reg        <= count_next;
      full_reg         <= (count_next == CNT_W'(DEPTH));
      empty_reg        <= (count_next == '0);
      almost_full_reg  <= (count_next >= CNT_W'(AF_LEVEL));
      almost_empty_reg <= (count_next <= CNT_W'(AE_LEVEL));
      ovf_reg          <= winc & full_reg;
      udf_reg          <= rinc & empty_reg;
    end
  end

  // Storage array is deliberately left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we)
      mem[wptr_reg] <= wdata;
  end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  // Head word falls through; hold_reg keeps the last popped word for the empty case.
  logic [DATA_W-1:0] hold_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hold_reg <= '0;
    else if (re)
      hold_reg <= mem[rptr_reg];
  end

  assign rdata = empty_reg ? hold_reg : mem[rptr_reg];
`else
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rdata_reg <= '0;
    else if (re)
      rdata_reg <= mem[rptr_reg];
  end

  assign rdata = rdata_reg;
`endif

  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;
  assign count        = count_reg;
  assign ovf          = ovf_reg;
  assign udf          = udf_reg;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo (DEPTH=8, AF=6, AE=2), both read modes.
module tb_param_sync_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int AF     = 6;
  localparam int AE     = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              winc = 1'b0;
  logic              rinc = 1'b0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] rdata;
  logic              full, empty, almost_full, almost_empty, ovf, udf;
  logic [CNT_W-1:0]  count;

  int n_assert = 0;
  int n_fail   = 0;

  param_sync_fifo #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .winc        (winc),
    .wdata       (wdata),
    .rinc        (rinc),
    .rdata       (rdata),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .ovf         (ovf),
    .udf         (udf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected flags follow directly from the occupancy the bench expects.
  task automatic chk_state(input string tag, input int c);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".empty"}, 32'(empty), 32'(c == 0));
    chk({tag, ".full"}, 32'(full), 32'(c == DEPTH));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(c >= AF));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(c <= AE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    tick;
    chk_state("reset", 0);
    chk("reset.rdata", 32'(rdata), 32'd0);
    chk("reset.ovf", 32'(ovf), 32'd0);
    chk("reset.udf", 32'(udf), 32'd0);
    #2 rst = 1'b0;
    tick;
    chk_state("idle", 0);
    $display("step reset: count=%0d empty=%0b rdata=%0d", count, empty, rdata);

    rinc = 1'b1;
    tick;
    rinc = 1'b0;
    chk("udf_idle.udf", 32'(udf), 32'd1);
    chk("udf_idle.count", 32'(count), 32'd0);
    tick;
    chk("udf_idle.udf_clear", 32'(udf), 32'd0);
    $display("step empty read: udf pulse checked, count=%0d", count);

    // Fill 1..8
    for (int i = 1; i <= DEPTH; i++) begin
      winc = 1'b1;
      wdata = 8'(i);
      tick;
      chk_state("fill", i);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
      chk("fill.rdata_fwft", 32'(rdata), 32'd1);
`else
      chk("fill.rdata", 32'(rdata), 32'd0);
`endif
      $display("fill write %0d: count=%0d af=%0b full=%0b", i, count, almost_full, full);
    end
    wdata = 8'd99;
    tick;
    winc = 1'b0;
    chk("ovf9.ovf", 32'(ovf), 32'd1);
    chk_state("ovf9", DEPTH);
    tick;
    chk("ovf9.ovf_clear", 32'(ovf), 32'd0);
    $display("write 99 at full: ovf checked, count=%0d", count);

    // Drain 1..8
    for (int i = 1; i <= DEPTH; i++) begin
      rinc = 1'b1;
`ifdef PARAM_SYNC_FIFO_FWFT_EN
      chk("drain.rdata_fwft", 32'(rdata), 32'(i));
      tick;
`else
      tick;
      chk("drain.rdata", 32'(rdata), 32'(i));
`endif
      chk_state("drain", DEPTH - i);
      $display("drain read %0d: rdata=%0d count=%0d", i, rdata, count);
    end
    rinc = 1'b0;
    tick;
    chk("drain.rdata_hold", 32'(rdata), 32'd8);
    chk("drain.udf", 32'(udf), 32'd0);

    // Wrap with simultaneous read/write
    for (int i = 1; i <= 3; i++) begin
      winc = 1'b1;
      wdata = 8'(10 * i);
      tick;
    end
    chk_state("prewrap", 3);
    for (int k = 0; k < 10; k++) begin
      winc = 1'b1;
      rinc = 1'b1;
      wdata = 8'(40 + k);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
      chk("wrap.rdata_fwft", 32'(rdata), (k < 3) ? 32'(10 * (k + 1)) : 32'(40 + k - 3));
      tick;
`else
      tick;
      chk("wrap.rdata", 32'(rdata), (k < 3) ? 32'(10 * (k + 1)) : 32'(40 + k - 3));
`endif
      chk("wrap.count", 32'(count), 32'd3);
      $display("wrap cycle %0d: wdata=%0d rdata=%0d count=%0d", k, 40 + k, rdata, count);
    end
    winc = 1'b0;
    rinc = 1'b0;

    // Boundary: simultaneous at full
    for (int i = 0; i < 5; i++) begin
      winc = 1'b1;
      wdata = 8'(50 + i);
      tick;
    end
    chk_state("refill", DEPTH);
    winc = 1'b1;
    rinc = 1'b1;
    wdata = 8'd77;
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    chk("full_both.rdata_fwft", 32'(rdata), 32'd47);
    tick;
`else
    tick;
    chk("full_both.rdata", 32'(rdata), 32'd47);
`endif
    winc = 1'b0;
    rinc = 1'b0;
    chk("full_both.ovf", 32'(ovf), 32'd1);
    chk_state("full_both", DEPTH - 1);
    $display("simultaneous at full: ovf=%0b count=%0d", ovf, count);
    for (int j = 0; j < DEPTH - 1; j++) begin
      rinc = 1'b1;
`ifdef PARAM_SYNC_FIFO_FWFT_EN
      chk("drain2.rdata_fwft", 32'(rdata), 32'(48 + j));
      tick;
`else
      tick;
      chk("drain2.rdata", 32'(rdata), 32'(48 + j));
`endif
      chk("drain2.count", 32'(count), 32'(DEPTH - 2 - j));
      $display("drain2 read %0d: rdata=%0d count=%0d", j, rdata, count);
    end

    // Boundary: simultaneous at empty
    winc = 1'b1;
    rinc = 1'b1;
    wdata = 8'd88;
    tick;
    winc = 1'b0;
    rinc = 1'b0;
    chk("empty_both.udf", 32'(udf), 32'd1);
    chk_state("empty_both", 1);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    chk("empty_both.rdata_fwft", 32'(rdata), 32'd88);
`else
    chk("empty_both.rdata_hold", 32'(rdata), 32'd54);
`endif
    $display("simultaneous at empty: udf=%0b count=%0d", udf, count);
    rinc = 1'b1;
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    chk("read88.rdata_fwft", 32'(rdata), 32'd88);
    tick;
`else
    tick;
    chk("read88.rdata", 32'(rdata), 32'd88);
`endif
    rinc = 1'b0;
    chk_state("read88", 0);
    $display("read after empty write: rdata=%0d", rdata);

    // Async reset mid-stream
    for (int i = 1; i <= 5; i++) begin
      winc = 1'b1;
      wdata = 8'(i);
      tick;
    end
    winc = 1'b0;
    chk_state("pre_rst", 5);
    #2 rst = 1'b1;
    #1;
    chk_state("async_rst", 0);
    chk("async_rst.rdata", 32'(rdata), 32'd0);
    $display("async reset mid-stream: count=%0d empty=%0b", count, empty);
    #1 rst = 1'b0;
    winc = 1'b1;
    wdata = 8'd7;
    tick;
    winc = 1'b0;
    rinc = 1'b1;
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    chk("post_rst.rdata_fwft", 32'(rdata), 32'd7);
    tick;
`else
    tick;
    chk("post_rst.rdata", 32'(rdata), 32'd7);
`endif
    rinc = 1'b0;
    chk_state("post_rst", 0);
    $display("write/read after reset: rdata=%0d", rdata);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Single-clock, parametrised FIFO with programmable width and depth. It is the successor to the team's fixed 8-bit FIFO and keeps the same winc/rinc/wdata/rdata handshake. New relative to that block: full/empty, almost-full/almost-empty, occupancy count, and overflow/underflow error pulses. Sits between producer and consumer logic in the SPI datapath, e.g. TX/RX byte buffering.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
CNT_W, $clog2(DEPTH+1), width of count output (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
winc  in  1  write request
wdata  in  DATA_W  write data, sampled with winc
rinc  in  1  read request
rdata  out  DATA_W  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  CNT_W  current occupancy, 0..DEPTH
ovf  out  1  one-cycle pulse: write rejected
udf  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset (rst high, async assert, sync-release to clk domain by the caller): wptr=rptr=0, count=0, rdata=0, empty=1, almost_empty=1, full=0, almost_full=0 (1 if AF_LEVEL==0, which is disallowed), ovf=0, udf=0. Memory contents are not reset.
- Write accept: we = winc & ~full. On a clk edge with we, mem[wptr] <= wdata and wptr increments.
- Read accept: re = rinc & ~empty. On a clk edge with re, rdata <= mem[rptr] and rptr increments.
- Read latency: rdata is valid on the edge after the accepting edge (1-cycle registered output). rdata holds its last value when no read is accepted.
- Pointers: log2(DEPTH) bits, wrapping naturally modulo DEPTH.
- count updates registered:
  - +1 on we only
  - -1 on re only
  - unchanged on both or neither
- All flags are registered and derived from the next count, so they are exact in the same cycle count changes.
- Simultaneous winc & rinc:
  - When neither full nor empty, both are accepted and count is unchanged.
  - When full, the read is accepted, the write is rejected, and ovf pulses.
  - When empty, the write is accepted, the read is rejected, and udf pulses. No bypass: the written word is read on a later request.
- ovf <= winc & full; udf <= rinc & empty. Each is a single-cycle registered pulse per rejected request.
- A rejected request has no effect on pointers, count, memory or rdata.
- Reset mid-operation: all state returns to reset values immediately, regardless of clk. In-flight data is discarded.

Optional Feature:
Macro: PARAM_SYNC_FIFO_FWFT_EN
- Defined (first-word fall-through):
  - rdata always presents mem[rptr] while not empty, combinationally from memory with no read latency.
  - rinc pops the head.
  - rdata equals the word written once empty drops, i.e. one cycle after the first write into an empty FIFO.
  - When empty, rdata holds its last value.
- Undefined: standard mode with 1-cycle registered read, as above.
- Flags, count, ovf and udf are identical in both modes.

Test Plan:
- Reset then idle (DATA_W=8, DEPTH=8, AF=6, AE=2):
  - empty=1, almost_empty=1, full=0, count=0, rdata=0.
  - rinc=1 for one cycle gives udf=1 for exactly one cycle; count stays 0.
- Fill: write 1,2,...,8 on consecutive cycles.
  - count steps 1..8.
  - almost_full rises when count=6; full=1 after the 8th write.
  - A 9th write (wdata=99) gives ovf pulse, count stays 8, and 99 is never read.
- Drain: 8 consecutive reads.
  - rdata = 1..8 in order, each one cycle after its read edge.
  - almost_empty rises at count=2; empty=1 after the last read.
- Wrap and simultaneous: write 10,20,30, then hold winc=rinc=1 for 10 cycles with wdata=40..49.
  - count stays 3 throughout.
  - Read sequence is 10,20,30,40,...,46; pointers wrap past 7 without error.
- Boundary simultaneous:
  - At full, winc=rinc=1 gives ovf=1 and count 8 to 7.
  - At empty, winc=rinc=1 gives udf=1 and count 0 to 1; the next read returns the written word.
- Async reset mid-stream: with count=5, pulse rst between clk edges.
  - Flags and count return to reset values immediately.
  - The subsequent write 7 and read returns 7.
- With PARAM_SYNC_FIFO_FWFT_EN defined, repeat Fill/Drain:
  - rdata=1 is visible with no rinc, one cycle after the first write.
  - Each rinc advances rdata in the same cycle.
